// File: rtl/ras_checker_pkg.sv
// Shared types for the commit-side return address stack checker.
// virt_t and ras_t match the fetch-side stack so restore beats can be pushed unchanged.
package ras_checker_pkg;

  typedef logic [31:0] virt_t;

  typedef struct packed {
    logic  valid;
    virt_t data;
  } ras_t;

  typedef enum logic [0:0] {
    RC_IDLE   = 1'b0,
    RC_REPAIR = 1'b1
  } ras_chk_state_t;

  localparam virt_t RAS_LINK_OFFSET = 32'd8;

  // Link address skips the delay slot and wraps modulo 2^32.
  function automatic virt_t ras_link_addr(input virt_t pc);
    return pc + RAS_LINK_OFFSET;
  endfunction

endpackage

// File: rtl/ras_checker_arch_stack.sv
// Architectural return address stack: index 0 is the top of the stack.
// Exposes both the current contents and the contents after this cycle's update.
module ras_arch_stack
  import ras_checker_pkg::*;
#(
  parameter int ENTRIES_NUM = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  virt_t                   link,
  output ras_t [ENTRIES_NUM-1:0]  arch,
  output ras_t [ENTRIES_NUM-1:0]  arch_next
);

  ras_t [ENTRIES_NUM-1:0] arch_r;
  ras_t [ENTRIES_NUM-1:0] next_s;

  // Push shifts down, pop shifts up, push+pop replaces the top in place.
  always_comb begin
    next_s = arch_r;
    case ({push, pop})
      2'b10: begin
        next_s[0] = '{valid: 1'b1, data: link};
        for (int i = 1; i < ENTRIES_NUM; i++) begin
          next_s[i] = arch_r[i-1];
        end
      end
      2'b01: begin
        for (int i = 0; i < ENTRIES_NUM - 1; i++) begin
          next_s[i] = arch_r[i+1];
        end
        next_s[ENTRIES_NUM-1] = '0;
      end
      2'b11: begin
        next_s[0] = '{valid: 1'b1, data: link};
      end
      default: begin
        next_s = arch_r;
      end
    endcase
  end

  // Stack storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      arch_r <= '0;
    end else begin
      arch_r <= next_s;
    end
  end

  assign arch      = arch_r;
  assign arch_next = next_s;

endmodule

// File: rtl/ras_checker.sv
// Commit-side return address checker: keeps the architectural stack, flags
// mispredicted returns and streams the stack back to fetch bottom-first.
module ras_checker
  import ras_checker_pkg::*;
#(
  parameter int ENTRIES_NUM = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  commit_valid,
  output logic  commit_ready,
  input  logic  commit_is_call,
  input  logic  commit_is_return,
  input  virt_t commit_pc,
  input  virt_t commit_target,
  input  logic  commit_pred_valid,
  input  virt_t commit_pred_target,
  output logic  mispredict,
  output virt_t mispredict_target,
  output logic  restore_valid,
  input  logic  restore_ready,
  output ras_t  restore_data,
  output logic  restore_last
);

  localparam int                 IDX_W    = $clog2(ENTRIES_NUM);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(ENTRIES_NUM - 1);

  ras_chk_state_t         state_r, state_next_s;
  logic [IDX_W-1:0]       beat_idx_r, beat_next_s;
  ras_t [ENTRIES_NUM-1:0] arch_s, arch_next_s;

  logic  accept_s, push_s, pop_s, miss_s, fire_s;
  logic  mispredict_r, restore_valid_r, restore_last_r;
  virt_t mispredict_target_r;
  ras_t  restore_data_r;

  assign commit_ready = (state_r == RC_IDLE);
  assign accept_s     = commit_valid && commit_ready;
  assign push_s       = accept_s && commit_is_call;
  assign pop_s        = accept_s && commit_is_return;
  assign miss_s       = pop_s && (!commit_pred_valid || (commit_pred_target != commit_target));
  assign fire_s       = restore_valid_r && restore_ready;

  ras_arch_stack #(
    .ENTRIES_NUM (ENTRIES_NUM)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .pop       (pop_s),
    .link      (ras_link_addr(commit_pc)),
    .arch      (arch_s),
    .arch_next (arch_next_s)
  );

  // FSM state and beat index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= RC_IDLE;
      beat_idx_r <= '0;
    end else begin
      state_r    <= state_next_s;
      beat_idx_r <= beat_next_s;
    end
  end

  // Next-state: enter REPAIR on a mispredict, walk beats down to index 0.
  always_comb begin
    state_next_s = state_r;
    beat_next_s  = beat_idx_r;
    case (state_r)
      RC_IDLE: begin
        if (miss_s) begin
          state_next_s = RC_REPAIR;
          beat_next_s  = LAST_IDX;
        end else begin
          state_next_s = RC_IDLE;
        end
      end
      RC_REPAIR: begin
        if (fire_s) begin
          if (beat_idx_r == IDX_W'(0)) begin
            state_next_s = RC_IDLE;
          end else begin
            beat_next_s = beat_idx_r - IDX_W'(1);
          end
        end else begin
          beat_next_s = beat_idx_r;
        end
      end
      default: begin
        state_next_s = RC_IDLE;
        beat_next_s  = '0;
      end
    endcase
  end

  // Registered outputs; the first beat comes from the post-commit stack image.
  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_r        <= 1'b0;
      mispredict_target_r <= '0;
      restore_valid_r     <= 1'b0;
      restore_data_r      <= '0;
      restore_last_r      <= 1'b0;
    end else begin
      mispredict_r <= miss_s;
      if (miss_s) begin
        mispredict_target_r <= commit_target;
        restore_valid_r     <= 1'b1;
        restore_data_r      <= arch_next_s[LAST_IDX];
        restore_last_r      <= 1'b0;
      end else if ((state_r == RC_REPAIR) && fire_s) begin
        if (beat_idx_r == IDX_W'(0)) begin
          restore_valid_r <= 1'b0;
          restore_data_r  <= '0;
          restore_last_r  <= 1'b0;
        end else begin
          restore_data_r <= arch_s[beat_idx_r - IDX_W'(1)];
          restore_last_r <= (beat_idx_r == IDX_W'(1));
        end
      end
    end
  end

  assign mispredict        = mispredict_r;
  assign mispredict_target = mispredict_target_r;
  assign restore_valid     = restore_valid_r;
  assign restore_data      = restore_data_r;
  assign restore_last      = restore_last_r;

endmodule
